deconv_col_feeder: RTL and testbench

//  Source side of the deconv column interface. Buffers one kernel (WEIGHT_SIZE weight columns)
//  and one feature map (FEATURE_SIZE columns). Streams them into the deconv column datapath
//  as load-enable pulses: each weight column is paired with every feature column, repeated for
//  N_CHANNEL channels. It advances only on the datapath's loop, column-done and channel requests.

---
 rtl/deconv_col_feeder_if.sv | 45 ++++
 rtl/deconv_col_feeder.sv | 151 +++++++++++++++
 tb/tb_deconv_col_feeder.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/deconv_col_feeder_if.sv
// Column feeder bus: buffer write port, stream handshakes and the load-pulse outputs.
// master = producer/datapath side, slave = deconv_col_feeder.
interface deconv_col_feeder_if #(
    parameter int WEIGHT_SIZE  = 5,
    parameter int BIT_WIDTH    = 8,
    parameter int FEATURE_SIZE = 8,
    parameter int N_CHANNEL    = 4,
    parameter int MAXS         = (WEIGHT_SIZE > FEATURE_SIZE) ? WEIGHT_SIZE : FEATURE_SIZE,
    parameter int ADDR_W       = (MAXS > 1) ? $clog2(MAXS) : 1
);
    localparam int KID_W = (WEIGHT_SIZE > 1) ? $clog2(WEIGHT_SIZE) : 1;
    localparam int FID_W = (FEATURE_SIZE > 1) ? $clog2(FEATURE_SIZE) : 1;

    logic                          i_wr_en;
    logic                          i_wr_sel;
    logic [ADDR_W-1:0]             i_wr_addr;
    logic [BIT_WIDTH*MAXS-1:0]     i_wr_data;
    logic                          i_start;
    logic                          i_fifo_loop;
    logic                          i_prcs_new_wcoln;
    logic                          i_prcs_new_chnl;
    logic [BIT_WIDTH*WEIGHT_SIZE-1:0]  o_weight_col;
    logic [BIT_WIDTH*FEATURE_SIZE-1:0] o_feature_map_col;
    logic                          o_enable_loadw;
    logic                          o_enable_loadip;
    logic [KID_W-1:0]              o_kernel_col_id;
    logic [FID_W-1:0]              o_input_col_id;
    logic                          o_ready;
    logic                          o_done;
    logic                          o_wr_drop;

    modport master (
        output i_wr_en, i_wr_sel, i_wr_addr, i_wr_data, i_start,
               i_fifo_loop, i_prcs_new_wcoln, i_prcs_new_chnl,
        input  o_weight_col, o_feature_map_col, o_enable_loadw, o_enable_loadip,
               o_kernel_col_id, o_input_col_id, o_ready, o_done, o_wr_drop
    );

    modport slave (
        input  i_wr_en, i_wr_sel, i_wr_addr, i_wr_data, i_start,
               i_fifo_loop, i_prcs_new_wcoln, i_prcs_new_chnl,
        output o_weight_col, o_feature_map_col, o_enable_loadw, o_enable_loadip,
               o_kernel_col_id, o_input_col_id, o_ready, o_done, o_wr_drop
    );
endinterface

// File: rtl/deconv_col_feeder.sv
// Buffers one kernel and one feature map, then streams weight/feature columns as
// load pulses into the deconv column datapath, paced by the datapath's handshakes.
module deconv_col_feeder #(
    parameter int WEIGHT_SIZE  = 5,
    parameter int BIT_WIDTH    = 8,
    parameter int FEATURE_SIZE = 8,
    parameter int N_CHANNEL    = 4,
    parameter int MAXS         = (WEIGHT_SIZE > FEATURE_SIZE) ? WEIGHT_SIZE : FEATURE_SIZE,
    parameter int ADDR_W       = (MAXS > 1) ? $clog2(MAXS) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    deconv_col_feeder_if.slave bus
);
    localparam int WW  = BIT_WIDTH * WEIGHT_SIZE;
    localparam int FW  = BIT_WIDTH * FEATURE_SIZE;
    localparam int K_W = (WEIGHT_SIZE > 1) ? $clog2(WEIGHT_SIZE) : 1;
    localparam int F_W = (FEATURE_SIZE > 1) ? $clog2(FEATURE_SIZE) : 1;
    localparam int C_W = (N_CHANNEL > 1) ? $clog2(N_CHANNEL) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(WEIGHT_SIZE - 1);
    localparam logic [F_W-1:0] F_LAST = F_W'(FEATURE_SIZE - 1);
    localparam logic [C_W-1:0] C_LAST = C_W'(N_CHANNEL - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_LOAD_IP, S_WAIT_IP, S_WAIT_WCOL, S_WAIT_CHNL, S_DONE
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [K_W-1:0]   r_k, w_k_nxt;
    logic [F_W-1:0]   r_f, w_f_nxt;
    logic [C_W-1:0]   r_c, w_c_nxt;

    logic [WW-1:0]    r_wbuf [WEIGHT_SIZE];
    logic [FW-1:0]    r_fbuf [FEATURE_SIZE];

    logic [WW-1:0]    r_weight_col;
    logic [FW-1:0]    r_feature_col;
    logic             r_loadw, r_loadip, r_done, r_wr_drop;

    logic             w_wr_inrange, w_wr_ok;
    logic [WW-1:0]    w_wcol_src;

    always_comb begin
        w_wr_inrange = bus.i_wr_sel ? (int'(bus.i_wr_addr) < FEATURE_SIZE)
                                    : (int'(bus.i_wr_addr) < WEIGHT_SIZE);
        w_wr_ok      = bus.i_wr_en && !i_rst && (r_state == S_IDLE) && w_wr_inrange;
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_ok) begin
            if (bus.i_wr_sel)
                r_fbuf[bus.i_wr_addr[F_W-1:0]] <= bus.i_wr_data[FW-1:0];
            else
                r_wbuf[bus.i_wr_addr[K_W-1:0]] <= bus.i_wr_data[WW-1:0];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_f_nxt     = r_f;
        w_c_nxt     = r_c;
        unique case (r_state)
            S_IDLE: begin
                if (bus.i_start) begin
                    w_k_nxt     = '0;
                    w_f_nxt     = '0;
                    w_c_nxt     = '0;
                    w_state_nxt = S_LOAD_W;
                end
            end
            S_LOAD_W:  w_state_nxt = S_LOAD_IP;
            S_LOAD_IP: w_state_nxt = S_WAIT_IP;
            S_WAIT_IP: begin
                if (bus.i_fifo_loop) begin
                    if (r_f < F_LAST) begin
                        w_f_nxt     = r_f + 1'b1;
                        w_state_nxt = S_LOAD_IP;
                    end else begin
                        w_f_nxt     = '0;
                        w_state_nxt = S_WAIT_WCOL;
                    end
                end
            end
            S_WAIT_WCOL: begin
                if (bus.i_prcs_new_wcoln) begin
                    if (r_k < K_LAST) begin
                        w_k_nxt     = r_k + 1'b1;
                        w_state_nxt = S_LOAD_W;
                    end else begin
                        w_k_nxt     = '0;
                        w_state_nxt = (r_c < C_LAST) ? S_WAIT_CHNL : S_DONE;
                    end
                end
            end
            S_WAIT_CHNL: begin
                if (bus.i_prcs_new_chnl) begin
                    w_c_nxt     = r_c + 1'b1;
                    w_state_nxt = S_LOAD_W;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A weight write landing on the same edge as i_start must reach the first column.
    always_comb begin
        w_wcol_src = r_wbuf[w_k_nxt];
        if (w_wr_ok && !bus.i_wr_sel && (bus.i_wr_addr[K_W-1:0] == w_k_nxt))
            w_wcol_src = bus.i_wr_data[WW-1:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_k           <= '0;
            r_f           <= '0;
            r_c           <= '0;
            r_loadw       <= 1'b0;
            r_loadip      <= 1'b0;
            r_done        <= 1'b0;
            r_wr_drop     <= 1'b0;
            r_weight_col  <= '0;
            r_feature_col <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_k       <= w_k_nxt;
            r_f       <= w_f_nxt;
            r_c       <= w_c_nxt;
            r_loadw   <= (w_state_nxt == S_LOAD_W);
            r_loadip  <= (w_state_nxt == S_LOAD_IP);
            r_done    <= (w_state_nxt == S_DONE);
            r_wr_drop <= bus.i_wr_en && !w_wr_ok;
            if (w_state_nxt == S_LOAD_W)
                r_weight_col <= w_wcol_src;
            if (w_state_nxt == S_LOAD_IP)
                r_feature_col <= r_fbuf[w_f_nxt];
        end
    end

    assign bus.o_weight_col      = r_weight_col;
    assign bus.o_feature_map_col = r_feature_col;
    assign bus.o_enable_loadw    = r_loadw;
    assign bus.o_enable_loadip   = r_loadip;
    assign bus.o_kernel_col_id   = r_k;
    assign bus.o_input_col_id    = r_f;
    assign bus.o_ready           = (r_state == S_IDLE);
    assign bus.o_done            = r_done;
    assign bus.o_wr_drop         = r_wr_drop;
endmodule

// File: tb/tb_deconv_col_feeder.sv
// Directed bench for deconv_col_feeder: table-driven buffer writes, then full streams,
// back-pressure, mid-stream reset and start-with-write sequences.
module tb_deconv_col_feeder;
    localparam int WS = 5;
    localparam int FS = 8;
    localparam int NC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    deconv_col_feeder_if bus ();

    deconv_col_feeder dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic        sel;
        logic [2:0]  addr;
        logic [63:0] data;
        logic        drop;
    } wr_vec_t;

    wr_vec_t     vec [15];
    logic [39:0] exp_w [WS];
    logic [63:0] exp_f [FS];
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_stream(input bit start_wr, input logic [63:0] sw_data, input string tag);
        int nw = 0, nip = 0, ndone = 0, done_cyc = 0;
        int loop_at = -1, wcol_at = -1, chnl_at = -1;
        bit prev_w = 1'b0;
        bus.i_start = 1'b1;
        if (start_wr) begin
            bus.i_wr_en   = 1'b1;
            bus.i_wr_sel  = 1'b0;
            bus.i_wr_addr = 3'd0;
            bus.i_wr_data = sw_data;
            exp_w[0]      = sw_data[39:0];
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            bus.i_start           = 1'b0;
            bus.i_wr_en           = 1'b0;
            bus.i_fifo_loop       = (cyc == loop_at);
            bus.i_prcs_new_wcoln  = (cyc == wcol_at);
            bus.i_prcs_new_chnl   = (cyc == chnl_at);
            if (cyc == 0) begin
                chk({tag, "_start_lat"}, bus.o_enable_loadw, 1'b1);
                chk({tag, "_start_drop"}, bus.o_wr_drop, 1'b0);
            end
            if (cyc == 20) begin
                bus.i_wr_en   = 1'b1;
                bus.i_wr_sel  = 1'b1;
                bus.i_wr_addr = 3'd3;
                bus.i_wr_data = 64'h0;
            end
            if (cyc == 21) chk({tag, "_busy_drop"}, bus.o_wr_drop, 1'b1);
            if (prev_w) chk({tag, "_w_then_ip"}, bus.o_enable_loadip, 1'b1);
            if (bus.o_enable_loadw) begin
                chk({tag, "_overlap"}, bus.o_enable_loadip, 1'b0);
                chk($sformatf("%s_wcol%0d", tag, nw), bus.o_weight_col, exp_w[nw % WS]);
                chk($sformatf("%s_kid%0d", tag, nw), bus.o_kernel_col_id, nw % WS);
                nw++;
            end
            if (bus.o_enable_loadip) begin
                chk($sformatf("%s_fcol%0d", tag, nip), bus.o_feature_map_col, exp_f[nip % FS]);
                chk($sformatf("%s_fid%0d", tag, nip), bus.o_input_col_id, nip % FS);
                nip++;
                loop_at = cyc + 1;
                if (nip % FS == 0) begin
                    wcol_at = cyc + 2;
                    if ((nw % WS == 0) && (nw < WS * NC)) chnl_at = cyc + 3;
                end
            end
            if (bus.o_done) begin
                ndone++;
                done_cyc = cyc;
            end
            prev_w = bus.o_enable_loadw;
            if (ndone > 0 && cyc >= done_cyc + 3) break;
        end
        bus.i_fifo_loop      = 1'b0;
        bus.i_prcs_new_wcoln = 1'b0;
        bus.i_prcs_new_chnl  = 1'b0;
        chk({tag, "_n_loadw"}, nw, WS * NC);
        chk({tag, "_n_loadip"}, nip, WS * FS * NC);
        chk({tag, "_n_done"}, ndone, 1);
        chk({tag, "_ready_end"}, bus.o_ready, 1'b1);
    endtask

    initial begin
        bus.i_wr_en = 1'b0; bus.i_wr_sel = 1'b0; bus.i_wr_addr = '0; bus.i_wr_data = '0;
        bus.i_start = 1'b0; bus.i_fifo_loop = 1'b0;
        bus.i_prcs_new_wcoln = 1'b0; bus.i_prcs_new_chnl = 1'b0;

        vec[0]  = '{1'b0, 3'd0, 64'hEEEEEE1111111111, 1'b0};
        vec[1]  = '{1'b0, 3'd1, 64'hEEEEEE2222222222, 1'b0};
        vec[2]  = '{1'b0, 3'd2, 64'hEEEEEE3333333333, 1'b0};
        vec[3]  = '{1'b0, 3'd3, 64'hEEEEEE4444444444, 1'b0};
        vec[4]  = '{1'b0, 3'd4, 64'hEEEEEE5555555555, 1'b0};
        vec[5]  = '{1'b1, 3'd0, 64'h8080808080808080, 1'b0};
        vec[6]  = '{1'b1, 3'd1, 64'h8181818181818181, 1'b0};
        vec[7]  = '{1'b1, 3'd2, 64'h8282828282828282, 1'b0};
        vec[8]  = '{1'b1, 3'd3, 64'hA5A5A5A5A5A5A5A5, 1'b0};
        vec[9]  = '{1'b1, 3'd4, 64'h8484848484848484, 1'b0};
        vec[10] = '{1'b1, 3'd5, 64'h8585858585858585, 1'b0};
        vec[11] = '{1'b1, 3'd6, 64'h8686868686868686, 1'b0};
        vec[12] = '{1'b1, 3'd7, 64'h8787878787878787, 1'b0};
        vec[13] = '{1'b0, 3'd5, 64'hFFFFFFFFFFFFFFFF, 1'b1};
        vec[14] = '{1'b0, 3'd7, 64'hFFFFFFFFFFFFFFFF, 1'b1};

        tick(); tick();
        rst = 1'b0;
        chk("rst_ready", bus.o_ready, 1'b1);
        chk("rst_loadw", bus.o_enable_loadw, 1'b0);
        chk("rst_loadip", bus.o_enable_loadip, 1'b0);
        chk("rst_done", bus.o_done, 1'b0);
        chk("rst_drop", bus.o_wr_drop, 1'b0);
        chk("rst_kid", bus.o_kernel_col_id, 0);
        chk("rst_fid", bus.o_input_col_id, 0);
        chk("rst_wcol", bus.o_weight_col, 0);
        chk("rst_fcol", bus.o_feature_map_col, 0);

        for (int i = 0; i < 15; i++) begin
            bus.i_wr_en   = 1'b1;
            bus.i_wr_sel  = vec[i].sel;
            bus.i_wr_addr = vec[i].addr;
            bus.i_wr_data = vec[i].data;
            tick();
            bus.i_wr_en = 1'b0;
            chk($sformatf("wr%0d_drop", i), bus.o_wr_drop, vec[i].drop);
            if (!vec[i].drop) begin
                if (vec[i].sel) exp_f[vec[i].addr] = vec[i].data;
                else            exp_w[vec[i].addr] = vec[i].data[39:0];
            end
        end
        tick();
        chk("drop_clears", bus.o_wr_drop, 1'b0);

        run_stream(1'b0, 64'h0, "s1");

        // Back-pressure in WAIT_IP with spurious handshakes, then reset mid-stream.
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        chk("bp_loadw", bus.o_enable_loadw, 1'b1);
        tick();
        chk("bp_loadip", bus.o_enable_loadip, 1'b1);
        for (int i = 0; i < 50; i++) begin
            bus.i_prcs_new_wcoln = (i % 7 == 3);
            bus.i_prcs_new_chnl  = (i % 11 == 5);
            bus.i_start          = (i == 10);
            tick();
            chk("bp_quiet", {bus.o_enable_loadw, bus.o_enable_loadip, bus.o_done}, 3'b000);
            chk("bp_wcol", bus.o_weight_col, exp_w[0]);
            chk("bp_fcol", bus.o_feature_map_col, exp_f[0]);
        end
        bus.i_prcs_new_wcoln = 1'b0;
        bus.i_prcs_new_chnl  = 1'b0;
        bus.i_start          = 1'b0;
        chk("bp_busy", bus.o_ready, 1'b0);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("mrst_loads", {bus.o_enable_loadw, bus.o_enable_loadip}, 2'b00);
        chk("mrst_ready", bus.o_ready, 1'b1);
        chk("mrst_ids", {bus.o_kernel_col_id, bus.o_input_col_id}, 0);
        chk("mrst_done", bus.o_done, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("mrst_idle", {bus.o_done, bus.o_enable_loadw, bus.o_enable_loadip, bus.o_ready}, 4'b0001);
        end

        run_stream(1'b1, 64'h0000_00C3_C3C3_C3C3, "s2");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
